// File: rtl/neurosync_pkg.sv
// rtl/neurosync_pkg.sv - opcodes, state encoding and record layout shared by the round sequencer
package neurosync_pkg;

  localparam logic [1:0] OP_BOTOES = 2'b00;
  localparam logic [1:0] OP_FAIXA  = 2'b01;
  localparam logic [1:0] OP_SERVO  = 2'b10;
  localparam logic [1:0] OP_SKIP   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_SETUP = 4'd2,
    ST_ARM   = 4'd3,
    ST_WAIT  = 4'd4,
    ST_SCORE = 4'd5,
    ST_NEXT  = 4'd6,
    ST_DONE  = 4'd7
  } state_t;

  // Fixed-width record fields; everything below them is the expected answer.
  localparam int OP_W    = 2;
  localparam int LEDS_W  = 4;
  localparam int POS_W   = 2;
  localparam int LIM_W   = 12;
  localparam int FIXED_W = OP_W + LEDS_W + POS_W + 2 * LIM_W;

  // Field LSB positions, packed from the MSB of a rec_w-bit record.
  function automatic int op_lsb(input int rec_w);
    return rec_w - OP_W;
  endfunction

  function automatic int leds_lsb(input int rec_w);
    return op_lsb(rec_w) - LEDS_W;
  endfunction

  function automatic int pos_lsb(input int rec_w);
    return leds_lsb(rec_w) - POS_W;
  endfunction

  function automatic int inf_lsb(input int rec_w);
    return pos_lsb(rec_w) - LIM_W;
  endfunction

  function automatic int sup_lsb(input int rec_w);
    return inf_lsb(rec_w) - LIM_W;
  endfunction

  function automatic int exp_w(input int rec_w);
    return rec_w - FIXED_W;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neurosync_round_sequencer_question_timer.sv
// rtl/neurosync_round_sequencer_question_timer.sv - per-question cycle counter with expiry flag
module question_timer #(
  parameter int TMR_W = 29,
  parameter int LIMIT = 500_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] count;

  // Count enabled cycles since the last clear; park on the last value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/neurosync_round_sequencer.sv
// rtl/neurosync_round_sequencer.sv - game-round sequencer walking per-mode question records
module neurosync_round_sequencer
  import neurosync_pkg::*;
#(
  parameter int N_MODES        = 4,
  parameter int N_QUESTIONS    = 8,
  parameter int REC_W          = 60,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int MODE_W         = clog2_min1(N_MODES),
  parameter int Q_W            = clog2_min1(N_QUESTIONS),
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MODE_W-1:0]     mode_sel,
  output logic [MODE_W+Q_W-1:0] rec_addr,
  input  logic [REC_W-1:0]      rec_data,
  output logic [1:0]            opcode,
  output logic [3:0]            leds,
  output logic [1:0]            pos_inicial,
  output logic [11:0]           lim_inf,
  output logic [11:0]           lim_sup,
  output logic [REC_W-33:0]     expected,
  output logic                  set_pos,
  output logic                  jogar,
  output logic                  medir,
  input  logic                  pronto_play,
  input  logic                  acertou_play,
  input  logic                  pronto_faixa,
  input  logic                  acertou_faixa,
  output logic [Q_W-1:0]        q_index,
  output logic [Q_W:0]          score,
  output logic                  result_valid,
  output logic                  result_hit,
  output logic                  timeout,
  output logic                  busy,
  output logic                  done,
  output logic                  mode_err,
  output logic [3:0]            db_estado
);

  localparam int OP_L   = op_lsb(REC_W);
  localparam int LEDS_L = leds_lsb(REC_W);
  localparam int POS_L  = pos_lsb(REC_W);
  localparam int INF_L  = inf_lsb(REC_W);
  localparam int SUP_L  = sup_lsb(REC_W);
  localparam int EXP_W  = exp_w(REC_W);

  localparam logic [Q_W-1:0] LAST_Q = Q_W'(N_QUESTIONS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [MODE_W-1:0] mode_q;
  logic [3:0]        leds_q;
  logic              clr_tmr;
  logic              en_tmr;
  logic              tmr_expired;
  logic              pronto_sel;
  logic              acertou_sel;
  logic              hit_nxt;
  logic              timeout_nxt;
  logic              round_start;
  logic              last_q;
  logic              mode_ok;

  question_timer #(
    .TMR_W (TMR_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr_tmr),
    .en      (en_tmr),
    .expired (tmr_expired)
  );

  // Range questions listen to the range checker, all others to the play analyser.
  assign pronto_sel  = (opcode == OP_FAIXA) ? pronto_faixa  : pronto_play;
  assign acertou_sel = (opcode == OP_FAIXA) ? acertou_faixa : acertou_play;
  assign last_q      = (q_index == LAST_Q);
  assign mode_ok     = (int'(mode_sel) < N_MODES);

  // Next-state and per-cycle controls; abort overrides whatever was decided.
  always_comb begin
    state_nxt   = state;
    clr_tmr     = 1'b0;
    en_tmr      = 1'b0;
    hit_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    round_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_FETCH;
          round_start = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_SETUP;
      ST_SETUP: begin
        clr_tmr   = 1'b1;
        state_nxt = (opcode == OP_SKIP) ? ST_SCORE : ST_ARM;
      end
      ST_ARM: state_nxt = ST_WAIT;
      ST_WAIT: begin
        en_tmr = 1'b1;
        if (pronto_sel) begin
          state_nxt = ST_SCORE;
          hit_nxt   = acertou_sel;
        end else if (tmr_expired) begin
          state_nxt   = ST_SCORE;
          timeout_nxt = 1'b1;
        end
      end
      ST_SCORE: state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = last_q ? ST_DONE : ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt   = ST_IDLE;
      round_start = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture every field of the current record during FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode      <= '0;
      leds_q      <= '0;
      pos_inicial <= '0;
      lim_inf     <= '0;
      lim_sup     <= '0;
      expected    <= '0;
    end else if (state == ST_FETCH) begin
      opcode      <= rec_data[OP_L +: OP_W];
      leds_q      <= rec_data[LEDS_L +: LEDS_W];
      pos_inicial <= rec_data[POS_L +: POS_W];
      lim_inf     <= rec_data[INF_L +: LIM_W];
      lim_sup     <= rec_data[SUP_L +: LIM_W];
      expected    <= rec_data[0 +: EXP_W];
    end
  end

  // Round bookkeeping: mode latch, question index and score; all held on abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      mode_err <= 1'b0;
      q_index  <= '0;
      score    <= '0;
    end else if (round_start) begin
      mode_q   <= mode_ok ? mode_sel : '0;
      mode_err <= !mode_ok;
      q_index  <= '0;
      score    <= '0;
    end else if (!abort) begin
      if (state == ST_SCORE && result_hit) begin
        score <= score + 1'b1;
      end
      if (state == ST_NEXT && !last_q) begin
        q_index <= q_index + 1'b1;
      end
    end
  end

  // Handshake pulses, registered so they line up with the state that owns them;
  // jogar is launched on the ARM to WAIT edge so it opens the wait window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_pos      <= 1'b0;
      jogar        <= 1'b0;
      medir        <= 1'b0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      set_pos      <= (state_nxt == ST_SETUP);
      jogar        <= (state == ST_ARM) && (state_nxt == ST_WAIT) && (opcode != OP_FAIXA);
      medir        <= (state_nxt == ST_WAIT) && (opcode == OP_FAIXA);
      result_valid <= (state_nxt == ST_SCORE);
      result_hit   <= (state_nxt == ST_SCORE) && hit_nxt;
      timeout      <= (state_nxt == ST_SCORE) && timeout_nxt;
    end
  end

  assign busy      = (state == ST_FETCH) || (state == ST_SETUP) || (state == ST_ARM) ||
                     (state == ST_WAIT)  || (state == ST_SCORE) || (state == ST_NEXT);
  assign done      = (state == ST_DONE);
  assign leds      = busy ? leds_q : 4'b1111;
  assign rec_addr  = {mode_q, q_index};
  assign db_estado = state;

endmodule

// File: tb/tb_neurosync_round_sequencer.sv
// tb/tb_neurosync_round_sequencer.sv - directed self-checking bench for the round sequencer
module tb_neurosync_round_sequencer;

  localparam int N_MODES = 3;
  localparam int N_Q     = 8;
  localparam int REC_W   = 60;
  localparam int TMO     = 100;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode_sel;
  logic [4:0]  rec_addr;
  logic [59:0] rec_data;
  logic [1:0]  opcode;
  logic [3:0]  leds;
  logic [1:0]  pos_inicial;
  logic [11:0] lim_inf;
  logic [11:0] lim_sup;
  logic [27:0] expected;
  logic        set_pos;
  logic        jogar;
  logic        medir;
  logic        pronto_play;
  logic        acertou_play;
  logic        pronto_faixa;
  logic        acertou_faixa;
  logic [2:0]  q_index;
  logic [3:0]  score;
  logic        result_valid;
  logic        result_hit;
  logic        timeout;
  logic        busy;
  logic        done;
  logic        mode_err;
  logic [3:0]  db_estado;

  logic [59:0] rom [0:31];
  assign rec_data = rom[rec_addr];

  neurosync_round_sequencer #(
    .N_MODES        (N_MODES),
    .N_QUESTIONS    (N_Q),
    .REC_W          (REC_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .mode_sel      (mode_sel),
    .rec_addr      (rec_addr),
    .rec_data      (rec_data),
    .opcode        (opcode),
    .leds          (leds),
    .pos_inicial   (pos_inicial),
    .lim_inf       (lim_inf),
    .lim_sup       (lim_sup),
    .expected      (expected),
    .set_pos       (set_pos),
    .jogar         (jogar),
    .medir         (medir),
    .pronto_play   (pronto_play),
    .acertou_play  (acertou_play),
    .pronto_faixa  (pronto_faixa),
    .acertou_faixa (acertou_faixa),
    .q_index       (q_index),
    .score         (score),
    .result_valid  (result_valid),
    .result_hit    (result_hit),
    .timeout       (timeout),
    .busy          (busy),
    .done          (done),
    .mode_err      (mode_err),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // responder configuration, indexed by question
  int delay_tab [N_Q];
  bit hit_tab   [N_Q];
  bit stray_tab [N_Q];

  // event log
  int         rv_cnt, hit_cnt, jogar_cnt, medir_cnt, medir_bad, jogar_bad, field_bad;
  int         first_jogar_cyc, start_cyc;
  int         rv_cyc [N_Q];
  int         wait_cyc [N_Q];
  int         fetch_cyc [N_Q];
  bit         rv_hit [N_Q];
  bit         rv_to [N_Q];
  logic [4:0] addr_log [N_Q];

  function automatic logic [59:0] mk(input logic [1:0] op, input int q);
    return {op, 4'(q + 1), 2'(q % 4), 12'(100 + q), 12'(200 + q), 28'(q * 16 + 7)};
  endfunction

  task automatic clear_log();
    rv_cnt = 0; hit_cnt = 0; jogar_cnt = 0; medir_cnt = 0;
    medir_bad = 0; jogar_bad = 0; field_bad = 0; first_jogar_cyc = 0;
    for (int i = 0; i < N_Q; i++) begin
      rv_cyc[i] = 0; wait_cyc[i] = 0; fetch_cyc[i] = 0;
      rv_hit[i] = 0; rv_to[i] = 0; addr_log[i] = '0;
    end
  endtask

  task automatic set_resp(input int dly, input bit hit);
    for (int i = 0; i < N_Q; i++) begin
      delay_tab[i] = dly; hit_tab[i] = hit; stray_tab[i] = 1'b0;
    end
  endtask

  task automatic start_round(input logic [1:0] m);
    @(negedge clock);
    mode_sel  = m;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string tag);
    int n = 0;
    while (db_estado != st && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, db_estado, st);
  endtask

  // scoreboard: samples outputs mid-cycle
  initial begin : monitor
    logic [3:0]  prev_st;
    logic [59:0] rec;
    prev_st = 4'd0;
    forever begin
      @(negedge clock);
      if (db_estado == 4'd1) begin
        fetch_cyc[q_index] = cyc;
        addr_log[q_index]  = rec_addr;
      end
      if (db_estado == 4'd4 && prev_st != 4'd4) wait_cyc[q_index] = cyc;
      if (jogar) begin
        jogar_cnt++;
        if (first_jogar_cyc == 0) first_jogar_cyc = cyc;
        if (db_estado != 4'd4) jogar_bad++;
      end
      if (medir) begin
        medir_cnt++;
        if (db_estado != 4'd4) medir_bad++;
      end
      if (result_valid) begin
        rv_cnt++;
        rv_hit[q_index] = result_hit;
        rv_to[q_index]  = timeout;
        rv_cyc[q_index] = cyc;
        if (result_hit) hit_cnt++;
        rec = rom[rec_addr];
        if (opcode != rec[59:58] || leds != rec[57:54] || pos_inicial != rec[53:52] ||
            lim_inf != rec[51:40] || lim_sup != rec[39:28] || expected != rec[27:0])
          field_bad++;
      end
      prev_st = db_estado;
    end
  end

  // play analyser / range checker model: answers delay_tab[q] cycles after arming
  initial begin : responder
    int   cnt;
    int   q;
    logic medir_d;
    cnt = -1; medir_d = 1'b0;
    pronto_play = 1'b0; acertou_play = 1'b0; pronto_faixa = 1'b0; acertou_faixa = 1'b0;
    forever begin
      @(negedge clock);
      pronto_play = 1'b0; acertou_play = 1'b0; pronto_faixa = 1'b0; acertou_faixa = 1'b0;
      q = int'(q_index);
      if (db_estado != 4'd4) begin
        cnt = -1;
      end else if (jogar || (medir && !medir_d)) begin
        cnt = delay_tab[q];
      end else if (cnt > 0) begin
        cnt--;
        if (stray_tab[q] && cnt == 10) begin
          pronto_faixa = 1'b1; acertou_faixa = 1'b1;
        end
        if (cnt == 0) begin
          if (opcode == 2'b01) begin
            pronto_faixa = 1'b1; acertou_faixa = hit_tab[q];
          end else begin
            pronto_play = 1'b1; acertou_play = hit_tab[q];
          end
          cnt = -1;
        end
      end
      medir_d = medir;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode_sel = 2'd0;
    for (int i = 0; i < 32; i++) rom[i] = mk(2'b00, i % 8);
    set_resp(20, 1'b1);
    clear_log();
    repeat (3) @(negedge clock);

    // reset values
    check("rst_state", db_estado, 4'd0);
    check("rst_leds", leds, 4'hF);
    check("rst_flags", {jogar, medir, set_pos, result_valid, result_hit, timeout, busy, done, mode_err}, 9'd0);
    check("rst_cnt", {score, q_index, rec_addr}, 12'd0);
    check("rst_fields", {opcode, pos_inicial, lim_inf, lim_sup, expected}, 60'd0);
    reset = 1'b1;
    @(negedge clock);

    // round 1: mode 2, all play questions, all hits
    clear_log();
    start_round(2'd2);
    wait_state(4'd7, 600, "r1_done_reached");
    check("r1_latency", first_jogar_cyc - start_cyc, 4);
    check("r1_rv_cnt", rv_cnt, 8);
    check("r1_hits", hit_cnt, 8);
    check("r1_score", score, 8);
    check("r1_done_busy", {done, busy}, 2'b10);
    check("r1_leds_idle", leds, 4'hF);
    check("r1_jogar", jogar_cnt, 8);
    check("r1_jogar_bad", jogar_bad, 0);
    check("r1_fields", field_bad, 0);
    check("r1_qidx", q_index, 7);
    for (int i = 0; i < N_Q; i++) check($sformatf("r1_addr%0d", i), addr_log[i], 5'h10 + 5'(i));

    // round 2: question 3 becomes a range question that misses
    rom[16 + 3] = mk(2'b01, 3);
    hit_tab[3]  = 1'b0;
    clear_log();
    start_round(2'd2);
    wait_state(4'd7, 600, "r2_done_reached");
    check("r2_rv_cnt", rv_cnt, 8);
    check("r2_hits", hit_cnt, 7);
    check("r2_score", score, 7);
    check("r2_q3_hit", rv_hit[3], 0);
    check("r2_medir_cnt", medir_cnt, 21);
    check("r2_medir_bad", medir_bad, 0);
    check("r2_jogar", jogar_cnt, 7);
    check("r2_fields", field_bad, 0);

    // round 3: timeout, then pronto on the expiry cycle
    set_resp(5, 1'b1);
    delay_tab[0] = -1;
    delay_tab[1] = TMO - 1;
    clear_log();
    start_round(2'd1);
    wait_state(4'd7, 800, "r3_done_reached");
    check("r3_q0_hit_to", {rv_hit[0], rv_to[0]}, 2'b01);
    check("r3_q0_gap", rv_cyc[0] - wait_cyc[0], TMO);
    check("r3_q1_hit_to", {rv_hit[1], rv_to[1]}, 2'b10);
    check("r3_q1_gap", rv_cyc[1] - wait_cyc[1], TMO);
    check("r3_score", score, 7);

    // round 4: skip record and a stray range pronto on a play question
    rom[0] = mk(2'b11, 0);
    set_resp(20, 1'b1);
    hit_tab[1]   = 1'b0;
    stray_tab[1] = 1'b1;
    clear_log();
    start_round(2'd0);
    wait_state(4'd7, 600, "r4_done_reached");
    check("r4_skip_gap", rv_cyc[0] - fetch_cyc[0], 2);
    check("r4_skip_hit_to", {rv_hit[0], rv_to[0]}, 2'b00);
    check("r4_jogar", jogar_cnt, 7);
    check("r4_medir", medir_cnt, 0);
    check("r4_stray_hit", rv_hit[1], 0);
    check("r4_stray_gap", rv_cyc[1] - wait_cyc[1], 21);
    check("r4_score", score, 6);
    check("r4_mode_err", mode_err, 0);

    // round 5: abort together with start in WAIT of question 5
    set_resp(20, 1'b1);
    hit_tab[3] = 1'b0;
    clear_log();
    start_round(2'd2);
    begin
      int n = 0;
      while (!(db_estado == 4'd4 && q_index == 3'd5) && n < 400) begin
        @(negedge clock);
        n++;
      end
    end
    check("r5_reach_q5", {db_estado, q_index}, {4'd4, 3'd5});
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    check("r5_state", db_estado, 4'd0);
    check("r5_qidx", q_index, 5);
    check("r5_score", score, 4);
    check("r5_pulses", {done, busy, jogar, medir, set_pos, result_valid}, 6'd0);
    check("r5_leds", leds, 4'hF);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("r5_still_idle", db_estado, 4'd0);

    // round 6: out-of-range mode, then asynchronous reset mid-WAIT
    clear_log();
    start_round(2'd3);
    check("r6_mode_err", mode_err, 1);
    check("r6_addr_mode", rec_addr[4:3], 2'd0);
    wait_state(4'd4, 100, "r6_wait_reached");
    #2;
    reset = 1'b0;
    #1;
    check("r6_rst_state", db_estado, 4'd0);
    check("r6_rst_leds", leds, 4'hF);
    check("r6_rst_flags", {jogar, medir, set_pos, result_valid, busy, done, mode_err}, 7'd0);
    check("r6_rst_cnt", {score, q_index, rec_addr}, 12'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
